// File: rtl/rand_range_sampler_pkg.sv
// -----------------------------------------------------------------------------
// rng_pkg
// Shared definitions for the random range sampler slice: the default width of
// the random word and the sampler state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package rng_pkg;

    // Width of the upstream LFSR word and of the configured range.
    localparam int RANDOM_LENGTH_DEF = 16;

    // IDLE: never configured, CALC: growing the mask, RUN: sampling.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RUN  = 2'd2
    } sampler_state_t;

endpackage

// File: rtl/rand_range_sampler_if.sv
// -----------------------------------------------------------------------------
// rand_range_sampler_if
// Bundles the random-word input, configuration and output handshake of the
// range sampler.
//   rand_in/rand_in_valid : fresh upstream LFSR word
//   cfg_load/cfg_range    : one-cycle pulse latching the range size N
//   out_data/out_valid/out_ready : buffered sample handshake
//   busy, reject_cnt      : status
// Modports: slave = the sampler, master = its environment.
// -----------------------------------------------------------------------------
interface rand_range_sampler_if
    import rng_pkg::*;
#(
    parameter int RANDOM_LENGTH = RANDOM_LENGTH_DEF
);

    logic [RANDOM_LENGTH-1:0] rand_in;
    logic                     rand_in_valid;
    logic                     cfg_load;
    logic [RANDOM_LENGTH-1:0] cfg_range;
    logic [RANDOM_LENGTH-1:0] out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     busy;
    logic [15:0]              reject_cnt;

    modport master (
        output rand_in, rand_in_valid, cfg_load, cfg_range, out_ready,
        input  out_data, out_valid, busy, reject_cnt
    );

    modport slave (
        input  rand_in, rand_in_valid, cfg_load, cfg_range, out_ready,
        output out_data, out_valid, busy, reject_cnt
    );

endinterface

// File: rtl/rand_range_sampler_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Small synchronous FIFO holding accepted samples.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : discard all entries (wins over push/pop)
//   push, din  : write request and data (ignored when full unless popping)
//   pop, dout  : read request and head-of-queue data (0 while empty)
//   full, empty: occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo
    import rng_pkg::*;
#(
    parameter int WIDTH = RANDOM_LENGTH_DEF,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int             AW        = $clog2(DEPTH);
    localparam logic [AW:0]    DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full buffer only lands when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through dout when counted.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/rand_range_sampler.sv
// -----------------------------------------------------------------------------
// rand_range_sampler
// Turns uniform LFSR words into uniform samples in 0..N-1 by masking each word
// down to the smallest all-ones mask covering N-1 and rejecting candidates
// that still land at or above N. Accepted samples are buffered in sync_fifo.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : rand_range_sampler_if.slave (inputs, output handshake, status)
// Parameters: RANDOM_LENGTH (word/range width), FIFO_DEPTH (buffer entries).
// Optional: define SAMPLER_STATS_EN to build the saturating rejection counter;
// otherwise reject_cnt reads as 0.
// -----------------------------------------------------------------------------
module rand_range_sampler
    import rng_pkg::*;
#(
    parameter int RANDOM_LENGTH = RANDOM_LENGTH_DEF,
    parameter int FIFO_DEPTH    = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    rand_range_sampler_if.slave bus
);

    localparam logic [RANDOM_LENGTH-1:0] ONE = RANDOM_LENGTH'(1);

    sampler_state_t           state;
    logic [RANDOM_LENGTH-1:0] range_n;
    logic [RANDOM_LENGTH-1:0] mask;
    logic [RANDOM_LENGTH-1:0] range_m1;
    logic [RANDOM_LENGTH-1:0] candidate;
    logic                     cand_ok;
    logic                     accept;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_full;
    logic                     fifo_empty;

    // N-1 wraps to all-ones for N=0, which makes the mask grow to full width.
    assign range_m1  = range_n - ONE;
    assign candidate = bus.rand_in & mask;
    assign cand_ok   = (range_n == '0) || (candidate < range_n);
    assign accept    = (state == RUN) && bus.rand_in_valid && cand_ok && !bus.cfg_load;
    assign fifo_pop  = bus.out_valid && bus.out_ready;
    assign fifo_push = accept && (!fifo_full || fifo_pop);

    // cfg_load restarts from any state; CALC shifts ones into the mask until it covers N-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            range_n <= '0;
            mask    <= '0;
        end else if (bus.cfg_load) begin
            state   <= CALC;
            range_n <= bus.cfg_range;
            mask    <= '0;
        end else begin
            case (state)
                CALC: begin
                    if (mask >= range_m1) begin
                        state <= RUN;
                    end else begin
                        mask <= {mask[RANDOM_LENGTH-2:0], 1'b1};
                    end
                end
                default: state <= state;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (RANDOM_LENGTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (bus.cfg_load),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (candidate),
        .dout  (bus.out_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.busy      = (state == CALC);

`ifdef SAMPLER_STATS_EN
    logic        reject;
    logic [15:0] reject_q;

    // Drops caused by a full buffer are not rejections; only out-of-range candidates count.
    assign reject = (state == RUN) && bus.rand_in_valid && !cand_ok && !bus.cfg_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reject_q <= '0;
        end else if (bus.cfg_load) begin
            reject_q <= '0;
        end else if (reject && (reject_q != 16'hFFFF)) begin
            reject_q <= reject_q + 16'd1;
        end
    end

    assign bus.reject_cnt = reject_q;
`else
    assign bus.reject_cnt = '0;
`endif

endmodule

// File: tb/tb_rand_range_sampler.sv
// -----------------------------------------------------------------------------
// tb_rand_range_sampler
// Self-checking bench for rand_range_sampler. A vector table covers the
// masking/acceptance function for several ranges; hand-written sequences cover
// buffer overflow, full-buffer streaming, flush on reconfiguration and
// asynchronous reset. Accepted samples are queued when driven and compared
// whenever the DUT pops one.
// -----------------------------------------------------------------------------
module tb_rand_range_sampler;

    localparam int W     = 16;
    localparam int DEPTH = 4;

    typedef struct {
        logic [W-1:0] range_n;
        logic [W-1:0] word;
        logic         exp_accept;
        logic [W-1:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    int          checks      = 0;
    int          errors      = 0;
    int          pop_count   = 0;
    int          exp_rejects = 0;
    logic [W-1:0] exp_q[$];

    rand_range_sampler_if #(.RANDOM_LENGTH(W)) bus();

    rand_range_sampler #(
        .RANDOM_LENGTH (W),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    // One comparison: count it, and report a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Expected reject_cnt as seen on the port for the current build.
    function automatic logic [31:0] expRejectPort();
`ifdef SAMPLER_STATS_EN
        return (exp_rejects > 32'hFFFF) ? 32'hFFFF : exp_rejects;
`else
        return 32'd0;
`endif
    endfunction

    // CALC length: one cycle per mask value 0, 1, 3, ... up to the bit length of N-1.
    function automatic int calcCycles(input logic [W-1:0] n);
        logic [W-1:0] m1;
        int           bits;
        m1   = n - 16'd1;
        bits = 0;
        for (int i = 0; i < W; i++) begin
            if (m1[i]) bits = i + 1;
        end
        return bits + 1;
    endfunction

    // Drive one word for one clock; queue the sample if it should be stored.
    task automatic applyStimulus(input logic [W-1:0] word, input logic exp_accept,
                                 input logic [W-1:0] exp_data, input logic exp_stored);
        bus.rand_in       = word;
        bus.rand_in_valid = 1'b1;
        if (exp_accept && exp_stored) exp_q.push_back(exp_data);
        if (!exp_accept) exp_rejects++;
        @(posedge clk);
        #1;
    endtask

    // Load a range, check the flush, and time the CALC phase.
    task automatic cfgLoad(input logic [W-1:0] n);
        int cycles;
        @(posedge clk);
        #1;
        bus.cfg_load      = 1'b1;
        bus.cfg_range     = n;
        bus.rand_in_valid = 1'b0;
        bus.out_ready     = 1'b0;
        exp_q.delete();
        exp_rejects = 0;
        @(posedge clk);
        #1;
        bus.cfg_load = 1'b0;
        checkOutput("flush_out_valid", bus.out_valid, 0);
        checkOutput("calc_busy", bus.busy, 1);
        checkOutput("cfg_reject_clear", bus.reject_cnt, 0);
        cycles = 0;
        while (bus.busy && cycles < 40) begin
            cycles++;
            @(posedge clk);
            #1;
        end
        checkOutput("calc_cycles", cycles, calcCycles(n));
    endtask

    // Let the buffer empty with out_ready high, bounded.
    task automatic drain();
        int c;
        bus.rand_in_valid = 1'b0;
        bus.out_ready     = 1'b1;
        c = 0;
        while (bus.out_valid && c < 20) begin
            c++;
            @(posedge clk);
            #1;
        end
        checkOutput("drain_done", bus.out_valid, 0);
    endtask

    // Scoreboard: every DUT pop must match the oldest expected sample.
    always @(posedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            pop_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pop actual=0x%0h required=no sample", bus.out_data);
            end else begin
                checkOutput("pop_data", bus.out_data, exp_q.pop_front());
            end
        end
    end

    // Global time limit so the run always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        vec_t         vecs[12];
        logic [W-1:0] cur_range;
        logic         first;
        int           pop_base;

        vecs[0]  = '{16'd10,  16'h1234, 1'b1, 16'd4};
        vecs[1]  = '{16'd10,  16'h000C, 1'b0, 16'd0};
        vecs[2]  = '{16'd10,  16'hFFF9, 1'b1, 16'd9};
        vecs[3]  = '{16'd10,  16'h000A, 1'b0, 16'd0};
        vecs[4]  = '{16'd1,   16'hABCD, 1'b1, 16'd0};
        vecs[5]  = '{16'd1,   16'hFFFF, 1'b1, 16'd0};
        vecs[6]  = '{16'd0,   16'hBEEF, 1'b1, 16'hBEEF};
        vecs[7]  = '{16'd0,   16'h0000, 1'b1, 16'h0000};
        vecs[8]  = '{16'd300, 16'h012B, 1'b1, 16'd299};
        vecs[9]  = '{16'd300, 16'hFE2C, 1'b1, 16'd44};
        vecs[10] = '{16'd300, 16'h012C, 1'b0, 16'd0};
        vecs[11] = '{16'd300, 16'h01FF, 1'b0, 16'd0};

        rst_n             = 1'b0;
        bus.cfg_load      = 1'b0;
        bus.cfg_range     = '0;
        bus.rand_in       = '0;
        bus.rand_in_valid = 1'b0;
        bus.out_ready     = 1'b0;

        // Reset values.
        #1;
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_out_data", bus.out_data, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_reject_cnt", bus.reject_cnt, 0);
        #11;
        rst_n = 1'b1;

        // Unconfigured: valid words must not produce samples.
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.rand_in       = 16'h0005;
            bus.rand_in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        checkOutput("idle_out_valid", bus.out_valid, 0);
        checkOutput("idle_busy", bus.busy, 0);
        bus.rand_in_valid = 1'b0;

        // Table-driven masking/acceptance vectors.
        first     = 1'b1;
        cur_range = '0;
        for (int i = 0; i < 12; i++) begin
            if (first || vecs[i].range_n != cur_range) begin
                cfgLoad(vecs[i].range_n);
                cur_range = vecs[i].range_n;
                first     = 1'b0;
            end
            bus.out_ready = 1'b1;
            applyStimulus(vecs[i].word, vecs[i].exp_accept, vecs[i].exp_data, 1'b1);
            checkOutput("vec_out_valid", bus.out_valid, vecs[i].exp_accept);
            if (vecs[i].exp_accept) checkOutput("vec_out_data", bus.out_data, vecs[i].exp_data);
            checkOutput("vec_reject_cnt", bus.reject_cnt, expRejectPort());
            bus.rand_in_valid = 1'b0;
            @(posedge clk);
            #1;
            checkOutput("vec_popped", bus.out_valid, 0);
        end

        // Overflow: six words into a 4-entry buffer with no consumer.
        cfgLoad(16'd16);
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(W'(k), 1'b1, W'(k), k <= DEPTH);
        end
        bus.rand_in_valid = 1'b0;
        checkOutput("full_out_valid", bus.out_valid, 1);
        checkOutput("full_head", bus.out_data, 1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("full_head_stable", bus.out_data, 1);
        checkOutput("full_no_reject", bus.reject_cnt, 0);
        pop_base = pop_count;
        drain();
        checkOutput("full_pop_count", pop_count - pop_base, DEPTH);
        checkOutput("full_queue_empty", exp_q.size(), 0);

        // Streaming at full: one push and one pop per cycle, nothing dropped.
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(16'h1000 | W'(k), 1'b1, W'(k), 1'b1);
        end
        pop_base      = pop_count;
        bus.out_ready = 1'b1;
        for (int k = 5; k <= 10; k++) begin
            applyStimulus(16'h2000 | W'(k), 1'b1, W'(k), 1'b1);
            checkOutput("stream_out_valid", bus.out_valid, 1);
        end
        checkOutput("stream_pops", pop_count - pop_base, 6);
        drain();
        checkOutput("stream_total_pops", pop_count - pop_base, 10);
        checkOutput("stream_queue_empty", exp_q.size(), 0);

        // Reconfigure with two samples buffered: they must vanish.
        bus.out_ready = 1'b0;
        applyStimulus(16'h0003, 1'b1, 16'd3, 1'b1);
        applyStimulus(16'h0007, 1'b1, 16'd7, 1'b1);
        bus.rand_in_valid = 1'b0;
        checkOutput("pre_flush_valid", bus.out_valid, 1);
        pop_base = pop_count;
        cfgLoad(16'd16);
        bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("post_flush_valid", bus.out_valid, 0);
        checkOutput("post_flush_pops", pop_count - pop_base, 0);

        // Asynchronous reset mid-RUN with three samples and one rejection.
        cfgLoad(16'd10);
        bus.out_ready = 1'b0;
        applyStimulus(16'h0001, 1'b1, 16'd1, 1'b1);
        applyStimulus(16'h0002, 1'b1, 16'd2, 1'b1);
        applyStimulus(16'h000F, 1'b0, 16'd0, 1'b1);
        applyStimulus(16'h0003, 1'b1, 16'd3, 1'b1);
        bus.rand_in_valid = 1'b0;
        checkOutput("pre_rst_valid", bus.out_valid, 1);
        checkOutput("pre_rst_reject_cnt", bus.reject_cnt, expRejectPort());
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", bus.out_valid, 0);
        checkOutput("async_rst_busy", bus.busy, 0);
        checkOutput("async_rst_reject_cnt", bus.reject_cnt, 0);
        checkOutput("async_rst_data", bus.out_data, 0);
        exp_q.delete();
        exp_rejects = 0;
        #10;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.rand_in       = 16'h0002;
            bus.rand_in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.rand_in_valid = 1'b0;
        checkOutput("post_rst_idle_valid", bus.out_valid, 0);
        checkOutput("post_rst_idle_busy", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rand_range_sampler.md
RAND_RANGE_SAMPLER -- requirements
Module: rand_range_sampler

Interface
REQ-001 The module SHALL have parameter RANDOM_LENGTH, default 16, giving the width of the random word and of the range.
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 4, giving the number of output buffer entries (power of two, at least 2).
REQ-003 The module SHALL have these ports:
- clk, input, 1: the single clock; all state changes on its rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- rand_in, input, RANDOM_LENGTH: word from the upstream 16-bit LFSR generator.
- rand_in_valid, input, 1: rand_in is a fresh word this cycle; low during the upstream seed load.
- cfg_load, input, 1: one-cycle pulse that latches cfg_range.
- cfg_range, input, RANDOM_LENGTH: N, the range size; outputs lie in 0..N-1; N=0 means the full 2^RANDOM_LENGTH range.
- out_data, output, RANDOM_LENGTH: head-of-buffer sample.
- out_valid, output, 1: out_data is valid.
- out_ready, input, 1: the consumer accepts out_data.
- busy, output, 1: the state is CALC.
- reject_cnt, output, 16: count of rejected candidates (see Configuration).

Function
REQ-004 The state machine SHALL have three states: IDLE (no configuration), CALC (building the mask) and RUN (sampling).
REQ-005 In any state, cfg_load SHALL latch N, flush the buffer, clear mask to 0 and enter CALC on the next edge.
REQ-006 In CALC, each cycle: if mask >= N-1 (mod 2^RANDOM_LENGTH), go to RUN; else mask <= {mask, 1'b1}. Takes at most RANDOM_LENGTH+1 cycles.
REQ-007 Mask boundary cases: N=1 gives mask 0 and enters RUN after 1 CALC cycle; N=0 gives mask all-ones.
REQ-008 In RUN, with rand_in_valid high, the candidate SHALL be rand_in & mask.
- Accept if candidate < N, or if N=0.
- Otherwise reject and discard.
REQ-009 An accepted candidate SHALL be written to the buffer on the same edge, and out_valid SHALL rise one cycle later (latency 1).
REQ-010 When the buffer is full and no pop occurs that cycle, accepted candidates SHALL be dropped; this is not counted as a rejection.
REQ-011 On a simultaneous push and pop, including at full or at one entry, both SHALL take effect and the occupancy is unchanged.
REQ-012 A pop SHALL occur exactly when out_valid and out_ready are both high; out_data SHALL remain stable while out_valid is high and out_ready is low.
REQ-013 In IDLE and CALC, no candidate SHALL be accepted.
REQ-014 cfg_load during RUN or CALC SHALL discard the buffered samples immediately (out_valid low the next cycle).
REQ-015 Buffer pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-016 Asserting rst_n low SHALL asynchronously force these reset values, mid-operation included:
- state IDLE, N=0, mask=0, buffer empty;
- out_valid=0, out_data=0, busy=0, reject_cnt=0.
REQ-017 After reset deassertion, the block SHALL stay in IDLE until the first cfg_load.

Configuration
REQ-018 The macro SAMPLER_STATS_EN SHALL control the rejection counter.
- Defined: reject_cnt increments by 1 per rejected candidate in RUN, saturates at 0xFFFF, and clears on cfg_load.
- Undefined: reject_cnt is tied to 0 with no counter logic; the port list is unchanged.

Structure
REQ-019 The shared package rng_pkg SHALL hold the RANDOM_LENGTH default and the sampler state enum (IDLE, CALC, RUN).
REQ-020 The output buffer SHALL be a sub-module sync_fifo with push, pop, full, empty, data in and data out; the mask logic and state machine stay at the top level.

Verification
REQ-021 Reset mid-RUN with 3 entries buffered -> out_valid=0, busy=0, reject_cnt=0 immediately, with no clk edge required.
REQ-022 cfg_range=10 -> busy high for 5 cycles (mask 0, 1, 3, 7, 15). Then:
- rand_in=0x1234 -> out_data=4 next cycle;
- rand_in=0x000C -> rejected, reject_cnt=1 (with SAMPLER_STATS_EN).
REQ-023 cfg_range=1 -> every valid word yields out_data=0; cfg_range=0 with rand_in=0xBEEF -> out_data=0xBEEF.
REQ-024 cfg_range=16, out_ready=0, 6 valid words -> buffer holds the first 4 in order, the last 2 are dropped, and out_data stays stable.
REQ-025 Buffer full while out_ready=1 and one acceptance per cycle -> one push and one pop per cycle, occupancy stays 4, no drops.
REQ-026 cfg_load during RUN with 2 entries buffered -> out_valid=0 on the next cycle, busy=1, and the old samples are never emitted.
